// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex driver for DIGITS common-anode 7-seg digits with frame-synchronous capture.
// Optional build macro SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
   logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  frame_q, frame_d;
   logic                  tick, wrap;
   logic [3:0]            nib;
   logic                  blank;

   always_comb begin
      tick = en && (presc_q == PRESC_LAST);
      wrap = tick && (idx_q == IDX_LAST);

      presc_d = presc_q;
      if (en) presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      // Shadow reloads only at the end of the last digit so a frame never mixes two values.
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      if (wrap) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
      end

      nib   = shadow_val_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_LEAD_ZERO_BLANK_EN
      blank = (idx_q != '0) && ((shadow_val_q >> {idx_q, 2'b00}) == '0);
`else
      blank = 1'b0;
`endif

      seg_d   = 7'b1111111;
      dp_d    = 1'b1;
      an_d    = '1;
      if (en) begin
         seg_d = blank ? 7'b1111111 : hex_to_seg(nib);
         dp_d  = ~shadow_dp_q[idx_q];
         an_d  = ~(DIGITS'(1) << idx_q);
      end
      frame_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         seg_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_q      <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_q      <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign dp    = dp_q;
   assign an    = an_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, REFRESH_DIV=4) with a cycle model and directed checks.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame;

   seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in),
      .seg(seg), .dp(dp), .an(an), .frame(frame)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [6:0] dec_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int          m_presc = 0;
   int          m_idx = 0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_dp = '0;
   logic [12:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [15:0] v, input logic [3:0] d);
      logic [12:0] ex;
      logic [6:0]  sg;
      logic        tk;
      logic        lead;
      rst = r; en = e; value = v; dp_in = d;
      if (r) begin
         ex = {4'hF, 7'h7F, 1'b1, 1'b0};
         m_presc = 0; m_idx = 0; m_val = '0; m_dp = '0;
      end else if (!e) begin
         ex = {4'hF, 7'h7F, 1'b1, 1'b0};
      end else begin
         sg = dec_tbl[m_val[4*m_idx +: 4]];
         lead = (m_idx != 0);
         for (int k = m_idx; k < 4; k++) if (m_val[4*k +: 4] != 4'h0) lead = 1'b0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
         if (lead) sg = 7'h7F;
`endif
         ex = {~(4'b0001 << m_idx), sg, ~m_dp[m_idx], (m_presc == 3 && m_idx == 3)};
         tk = (m_presc == 3);
         if (tk && m_idx == 3) begin m_val = v; m_dp = d; end
         m_presc = tk ? 0 : m_presc + 1;
         if (tk) m_idx = (m_idx == 3) ? 0 : m_idx + 1;
      end
      exp_q.push_back(ex);
      @(posedge clk); #1;
      ex = exp_q.pop_front();
      chk("an",    32'(an),    32'(ex[12:9]));
      chk("seg",   32'(seg),   32'(ex[8:2]));
      chk("dp",    32'(dp),    32'(ex[1]));
      chk("frame", 32'(frame), 32'(ex[0]));
   endtask

   logic [3:0] an_tbl  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_tbl [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};

   initial begin
      int n;
      // reset held two cycles, then first enabled cycle shows digit 0 as "0"
      step(1, 0, 16'h1A3F, 4'h0);
      step(1, 0, 16'h1A3F, 4'h0);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_frame", 32'(frame), 32'h0);
      step(0, 1, 16'h1A3F, 4'h0);
      chk("first_an", 32'(an), 32'hE);
      chk("first_seg", 32'(seg), 32'(7'b1000000));

      // frame pulse latency and the first loaded frame
      n = 1;
      while (frame !== 1'b1 && n < 40) begin
         step(0, 1, 16'h1A3F, 4'h0);
         n++;
      end
      chk("frame_lat", 32'(n), 32'd16);
      for (int k = 0; k < 16; k++) begin
         step(0, 1, 16'h1A3F, 4'h0);
         chk("f_an", 32'(an), 32'(an_tbl[k/4]));
         chk("f_seg", 32'(seg), 32'(seg_tbl[k/4]));
      end

      // mid-frame value change stays hidden until the next reload
      for (int k = 0; k < 6; k++) step(0, 1, 16'h1A3F, 4'h0);
      for (int k = 0; k < 34; k++) step(0, 1, 16'h0000, 4'h0);

      // enable gap mid-digit
      for (int k = 0; k < 6; k++) step(0, 1, 16'hC0DE, 4'h0);
      for (int k = 0; k < 10; k++) step(0, 0, 16'hC0DE, 4'h0);
      chk("dis_an", 32'(an), 32'hF);
      chk("dis_seg", 32'(seg), 32'h7F);
      for (int k = 0; k < 36; k++) step(0, 1, 16'hC0DE, 4'h0);

      // leading zeros (blanked only when the macro is defined)
      for (int k = 0; k < 40; k++) step(0, 1, 16'h0050, 4'h0);

      // decimal point on digit 2, then reset in the middle of a scan
      for (int k = 0; k < 37; k++) step(0, 1, 16'h9876, 4'b0100);
      step(1, 1, 16'h9876, 4'b0100);
      chk("mid_rst_an", 32'(an), 32'hF);
      chk("mid_rst_seg", 32'(seg), 32'h7F);
      chk("mid_rst_dp", 32'(dp), 32'h1);
      for (int k = 0; k < 20; k++) step(0, 1, 16'h4B2D, 4'b1001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
